// File: rtl/ifu_fetch_pkg.sv
// Shared constants and FSM state encoding for the instruction fetch unit.
package ifu_fetch_pkg;

    localparam logic [31:0] IFU_RST_PC = 32'h8000_0000;
    localparam logic [31:0] IFU_NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_OUT   = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_redirect_latch.sv
// Holds the most recent redirect target from execute until the fetch FSM consumes it.
module ifu_redirect_latch #(
    parameter int unsigned DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jump_valid,
    input  logic [DATA_LEN-1:0] jump_pc,
    input  logic                clear,
    output logic                redirect_pending,
    output logic [DATA_LEN-1:0] redirect_pc
);

    // A clear coincides with a jump only when that jump is the target being consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_pending <= 1'b0;
            redirect_pc      <= '0;
        end else if (clear) begin
            redirect_pending <= 1'b0;
        end else if (jump_valid) begin
            redirect_pending <= 1'b1;
            redirect_pc      <= jump_pc;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: FETCH/WAIT/OUT fetch FSM with redirect handling.
// Optional misaligned-PC fault reporting enabled by defining IFU_MISALIGN_CHK_EN.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned         DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RST_PC   = IFU_RST_PC
) (
    input  logic                clk,
    input  logic                rst,
    output logic [DATA_LEN-1:0] araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [31:0]         rdata,
    input  logic                rvalid,
    output logic                rready,
    output logic [31:0]         inst,
    output logic [DATA_LEN-1:0] PC,
    output logic                inst_valid,
    input  logic                inst_ready,
    input  logic                jump_valid,
    input  logic [DATA_LEN-1:0] jump_pc,
    output logic                inst_fault
);

    ifu_state_e          state;
    ifu_state_e          next_state;
    logic [DATA_LEN-1:0] pc_q;
    logic [DATA_LEN-1:0] pc_d;
    logic [31:0]         inst_q;
    logic [31:0]         inst_d;
    logic                redirect_pending;
    logic [DATA_LEN-1:0] redirect_pc;
    logic                redirect_clear;
    logic                redirect_hit;
    logic [DATA_LEN-1:0] redirect_target;

    ifu_redirect_latch #(
        .DATA_LEN(DATA_LEN)
    ) u_redirect_latch (
        .clk              (clk),
        .rst              (rst),
        .jump_valid       (jump_valid),
        .jump_pc          (jump_pc),
        .clear            (redirect_clear),
        .redirect_pending (redirect_pending),
        .redirect_pc      (redirect_pc)
    );

    // A same-cycle pulse is newer than anything already latched.
    assign redirect_hit    = jump_valid | redirect_pending;
    assign redirect_target = jump_valid ? jump_pc : redirect_pc;

    assign inst = inst_q;
    assign PC   = pc_q;

`ifdef IFU_MISALIGN_CHK_EN
    logic fault_q;
    logic fault_d;

    assign araddr     = pc_q;
    assign inst_fault = fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign araddr     = {pc_q[DATA_LEN-1:2], 2'b00};
    assign inst_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RST_PC;
            inst_q <= IFU_NOP;
        end else begin
            pc_q   <= pc_d;
            inst_q <= inst_d;
        end
    end

    always_comb begin
        next_state     = state;
        pc_d           = pc_q;
        inst_d         = inst_q;
        redirect_clear = 1'b0;
        arvalid        = 1'b0;
        rready         = 1'b0;
        inst_valid     = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
        fault_d        = fault_q;
`endif
        case (state)
            ST_FETCH: begin
`ifdef IFU_MISALIGN_CHK_EN
                // A misaligned PC never reaches memory; a redirect here is applied at once.
                if (pc_q[1:0] != 2'b00) begin
                    if (redirect_hit) begin
                        pc_d           = redirect_target;
                        redirect_clear = 1'b1;
                    end else begin
                        next_state = ST_OUT;
                        inst_d     = IFU_NOP;
                        fault_d    = 1'b1;
                    end
                end else begin
                    arvalid = ~rst;
                    if (arready) begin
                        next_state = ST_WAIT;
                    end
                end
`else
                arvalid = ~rst;
                if (arready) begin
                    next_state = ST_WAIT;
                end
`endif
            end
            ST_WAIT: begin
                rready = ~rst;
                if (rvalid) begin
                    if (redirect_hit) begin
                        pc_d       = redirect_target;
                        next_state = ST_FETCH;
                    end else begin
                        inst_d     = rdata;
                        next_state = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                inst_valid = ~rst;
                if (redirect_hit) begin
                    pc_d       = redirect_target;
                    next_state = ST_FETCH;
`ifdef IFU_MISALIGN_CHK_EN
                    fault_d    = 1'b0;
`endif
                end else if (inst_ready) begin
                    pc_d       = pc_q + DATA_LEN'(4);
                    next_state = ST_FETCH;
`ifdef IFU_MISALIGN_CHK_EN
                    fault_d    = 1'b0;
`endif
                end
            end
            default: begin
                next_state = ST_FETCH;
            end
        endcase
        if ((next_state == ST_FETCH) && (state != ST_FETCH)) begin
            redirect_clear = 1'b1;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios, then randomized traffic against
// a delivered-instruction scoreboard. Define IFU_MISALIGN_CHK_EN to match the RTL build.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] PC;
    logic        inst_valid;
    logic        inst_ready;
    logic        jump_valid;
    logic [31:0] jump_pc;
    logic        inst_fault;

    int          checks    = 0;
    int          errors    = 0;
    int          delivered = 0;
    logic [31:0] mem_q[$];
    logic [31:0] exp_pc;
    logic        prev_ar_hold;
    logic        prev_out_hold;
    logic [31:0] prev_araddr;
    logic [31:0] prev_inst;
    logic [31:0] prev_pc;
    logic        rnd_jump;

    always #5 clk = ~clk;

    ifu_fetch #(
        .DATA_LEN (32),
        .RST_PC   (32'h8000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .PC         (PC),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .jump_valid (jump_valid),
        .jump_pc    (jump_pc),
        .inst_fault (inst_fault)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // What decode should receive for a given PC.
    function automatic logic [31:0] expectedInst(input logic [31:0] pc);
`ifdef IFU_MISALIGN_CHK_EN
        return (pc[1:0] != 2'b00) ? NOP : memWord(pc);
`else
        return memWord({pc[31:2], 2'b00});
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ar, input logic rv_en, input logic ir,
                                 input logic jv, input logic [31:0] jpc);
        rst        = r;
        arready    = ar;
        inst_ready = ir;
        jump_valid = jv;
        jump_pc    = jpc;
        rvalid     = rv_en && !r && (mem_q.size() > 0);
        rdata      = rvalid ? memWord(mem_q[0]) : $urandom;
        #1;
    endtask

    // Scoreboard and protocol checks on the settled cycle, then advance one clock.
    task automatic endCycle();
        logic        push;
        logic        pop;
        logic [31:0] push_addr;
        push      = 1'b0;
        pop       = 1'b0;
        push_addr = '0;
        if (rst) begin
            exp_pc        = RESET_PC;
            prev_ar_hold  = 1'b0;
            prev_out_hold = 1'b0;
            mem_q.delete();
        end else begin
            if (prev_ar_hold) begin
                checkOutput("arvalid_hold", 32'(arvalid), 32'd1);
                checkOutput("araddr_stable", araddr, prev_araddr);
            end
            if (prev_out_hold) begin
                checkOutput("inst_valid_hold", 32'(inst_valid), 32'd1);
                checkOutput("inst_stable", inst, prev_inst);
                checkOutput("pc_stable", PC, prev_pc);
            end
            checkOutput("ar_out_exclusive", 32'(arvalid & inst_valid), 32'd0);
            if (jump_valid) begin
                exp_pc = jump_pc;
            end else if (inst_valid && inst_ready) begin
                checkOutput("deliver_pc", PC, exp_pc);
                checkOutput("deliver_inst", inst, expectedInst(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (arvalid && arready) begin
                push      = 1'b1;
                push_addr = araddr;
            end
            pop           = rvalid && rready;
            prev_ar_hold  = arvalid && !arready;
            prev_araddr   = araddr;
            prev_out_hold = inst_valid && !inst_ready && !jump_valid;
            prev_inst     = inst;
            prev_pc       = PC;
        end
        @(posedge clk);
        if (pop) begin
            void'(mem_q.pop_front());
        end
        if (push) begin
            mem_q.push_back(push_addr);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        arready       = 1'b0;
        rvalid        = 1'b0;
        rdata         = '0;
        inst_ready    = 1'b0;
        jump_valid    = 1'b0;
        jump_pc       = '0;
        exp_pc        = RESET_PC;
        prev_ar_hold  = 1'b0;
        prev_out_hold = 1'b0;
        prev_araddr   = '0;
        prev_inst     = '0;
        prev_pc       = '0;
        rnd_jump      = 1'b0;

        // Reset values
        repeat (2) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            endCycle();
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("rst_arvalid", 32'(arvalid), 32'd0);
        checkOutput("rst_rready", 32'(rready), 32'd0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_inst_fault", 32'(inst_fault), 32'd0);
        checkOutput("rst_pc", PC, RESET_PC);
        checkOutput("rst_inst", inst, NOP);
        endCycle();

        // First fetch: 3-cycle latency
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("c1_arvalid", 32'(arvalid), 32'd1);
        checkOutput("c1_araddr", araddr, 32'h8000_0000);
        checkOutput("c1_inst_valid", 32'(inst_valid), 32'd0);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("c2_rready", 32'(rready), 32'd1);
        checkOutput("c2_arvalid", 32'(arvalid), 32'd0);
        checkOutput("c2_inst_valid", 32'(inst_valid), 32'd0);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("c3_inst_valid", 32'(inst_valid), 32'd1);
        checkOutput("c3_pc", PC, 32'h8000_0000);
        checkOutput("c3_inst", inst, memWord(32'h8000_0000));
        endCycle();

        // Decode stall for 5 cycles in total
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput("stall_inst_valid", 32'(inst_valid), 32'd1);
            checkOutput("stall_no_arvalid", 32'(arvalid), 32'd0);
            checkOutput("stall_pc", PC, 32'h8000_0000);
            endCycle();
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("stall_release_valid", 32'(inst_valid), 32'd1);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("seq_araddr", araddr, 32'h8000_0004);
        checkOutput("seq_arvalid", 32'(arvalid), 32'd1);
        endCycle();

        // Redirect while waiting, response arrives two cycles later and is dropped
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0100);
        checkOutput("wait_rready", 32'(rready), 32'd1);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("wait_no_valid", 32'(inst_valid), 32'd0);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("wait_drop_no_valid", 32'(inst_valid), 32'd0);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("wait_redir_valid", 32'(inst_valid), 32'd0);
        checkOutput("wait_redir_araddr", araddr, 32'h8000_0100);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        endCycle();

        // Redirect and inst_ready together in OUT: redirect wins
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0040);
        checkOutput("out_redir_valid", 32'(inst_valid), 32'd1);
        checkOutput("out_redir_pc", PC, 32'h8000_0100);
        endCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("out_redir_drop", 32'(inst_valid), 32'd0);
        checkOutput("out_redir_araddr", araddr, 32'h8000_0040);
        endCycle();

        // Two redirects while the address is stalled: last one wins
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0200);
        checkOutput("fetch_jmp1_araddr", araddr, 32'h8000_0040);
        endCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0300);
        checkOutput("fetch_jmp2_araddr", araddr, 32'h8000_0040);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("last_wins_discard_valid", 32'(inst_valid), 32'd0);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("last_wins_araddr", araddr, 32'h8000_0300);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("last_wins_pc", PC, 32'h8000_0300);
        endCycle();

        // PC wraps modulo 2^32
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        checkOutput("wrap_old_araddr", araddr, 32'h8000_0304);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_top_araddr", araddr, 32'hFFFF_FFFC);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("wrap_top_pc", PC, 32'hFFFF_FFFC);
        endCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_zero_araddr", araddr, 32'h0000_0000);
        endCycle();

        // Reset in the middle of a transaction
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        endCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("midrst_rready", 32'(rready), 32'd0);
        checkOutput("midrst_arvalid", 32'(arvalid), 32'd0);
        endCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("midrst_arvalid_after", 32'(arvalid), 32'd1);
        checkOutput("midrst_araddr_after", araddr, 32'h8000_0000);
        endCycle();

`ifdef IFU_MISALIGN_CHK_EN
        // Misaligned target yields a faulting NOP without a memory request
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0002);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("mis_no_arvalid", 32'(arvalid), 32'd0);
        checkOutput("mis_no_valid_yet", 32'(inst_valid), 32'd0);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("mis_inst_valid", 32'(inst_valid), 32'd1);
        checkOutput("mis_inst_nop", inst, NOP);
        checkOutput("mis_fault", 32'(inst_fault), 32'd1);
        checkOutput("mis_pc", PC, 32'h8000_0002);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0400);
        checkOutput("mis_fault_cleared", 32'(inst_fault), 32'd0);
        checkOutput("mis_next_no_arvalid", 32'(arvalid), 32'd0);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("mis_recover_araddr", araddr, 32'h8000_0400);
        endCycle();
`else
        // Misaligned target fetches from the aligned word and never faults
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0502);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("unal_arvalid", 32'(arvalid), 32'd1);
        checkOutput("unal_araddr", araddr, 32'h8000_0500);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("unal_pc", PC, 32'h8000_0502);
        checkOutput("unal_inst", inst, memWord(32'h8000_0500));
        checkOutput("unal_fault", 32'(inst_fault), 32'd0);
        endCycle();
`endif

        // Randomized traffic with random back-pressure and redirects
        for (int i = 0; i < 3000; i++) begin
            rnd_jump = ($urandom_range(0, 9) == 0);
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), rnd_jump,
                          32'h8000_0000 | 32'($urandom_range(0, 255) << 2));
            endCycle();
        end
        checkOutput("progress", 32'(delivered > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
